// File: rtl/spi_bus_arb.sv
// spi_bus_arb: sole owner of the shared AFE/EEPROM SPI bus.
// Three requesters (0 = channel gain, 1 = trigger level, 2 = EEPROM) are
// arbitrated round-robin. Each grant runs one 16-bit mode-0 frame on the
// addressed slave select and returns the MISO word to that requester.
//
// Ports:
//   clk, rst                 system clock, async active-high reset
//   req[2:0]                 request levels, sampled only while idle
//   wdata_0..2, sel_0..2     frame payload and target slave per requester
//   gnt[2:0], done[2:0]      one-cycle accept / completion pulses
//   err                      pulses with done when sel addressed no slave
//   rdata[15:0]              received word, valid from the done cycle
//   busy                     high while a frame or its trailing gap runs
//   SCLK, MOSI, MISO         SPI bus
//   ch1/ch2/ch3/trig/EEP_ss_n  active-low slave selects
//
// State   | meaning
// IDLE    | arbitrate; req sampled only here
// FRONT   | select asserted, SCLK low, MOSI = bit 15 (D clocks)
// SHIFT   | 16 SCLK pulses, ends on the 16th falling edge
// BACK    | select held, SCLK low (D clocks)
// GAP     | all selects high, busy still high (D clocks)
module spi_bus_arb #(
  parameter int SCLK_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] wdata_0,
  input  logic [15:0] wdata_1,
  input  logic [15:0] wdata_2,
  input  logic [2:0]  sel_0,
  input  logic [2:0]  sel_1,
  input  logic [2:0]  sel_2,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        ch1_ss_n,
  output logic        ch2_ss_n,
  output logic        ch3_ss_n,
  output logic        trig_ss_n,
  output logic        EEP_ss_n
);

  localparam int CW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SCLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP} state_t;

  state_t      state, state_d;
  logic [CW-1:0] cnt;
  logic [4:0]  hcnt;
  logic        sclk_q;
  logic [15:0] tx, rx;
  logic [2:0]  sel_q;
  logic [1:0]  owner, last;
  logic        tc, active, illegal;
  logic        win_vld;
  logic [1:0]  win, cand0, cand1, cand2;
  logic [15:0] wd_win;
  logic [2:0]  sel_win;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  assign tc      = (cnt == '0);
  assign active  = (state == FRONT) || (state == SHIFT) || (state == BACK);
  assign illegal = (sel_q > 3'd4);

  // Rotated priority: the requester after the last one granted goes first.
  assign cand0 = nxt(last);
  assign cand1 = nxt(cand0);
  assign cand2 = nxt(cand1);

  always_comb begin
    win_vld = 1'b1;
    win     = cand0;
    if (req[cand0])      win = cand0;
    else if (req[cand1]) win = cand1;
    else if (req[cand2]) win = cand2;
    else                 win_vld = 1'b0;
  end

  always_comb begin
    wd_win  = wdata_0;
    sel_win = sel_0;
    case (win)
      2'd1:    begin wd_win = wdata_1; sel_win = sel_1; end
      2'd2:    begin wd_win = wdata_2; sel_win = sel_2; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    gnt     = 3'b000;
    case (state)
      IDLE: begin
        // gated by rst so gnt reads zero while reset is held
        if (win_vld && !rst) begin
          gnt     = onehot(win);
          state_d = FRONT;
        end
      end
      FRONT: if (tc) state_d = SHIFT;
      // the 16th fall ends SHIFT; the trailing low half-period is BACK
      SHIFT: if (tc && hcnt == 5'd30) state_d = BACK;
      BACK:  if (tc) state_d = GAP;
      GAP:   if (tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      hcnt   <= '0;
      sclk_q <= 1'b0;
      tx     <= '0;
      rx     <= '0;
      sel_q  <= '0;
      owner  <= '0;
      last   <= 2'd2;
      done   <= '0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      if (state_d != state || (state == SHIFT && tc)) cnt <= CNT_LOAD;
      else if (!tc)                                   cnt <= cnt - 1'b1;
      case (state)
        IDLE: begin
          if (win_vld) begin
            tx     <= wd_win;
            sel_q  <= sel_win;
            owner  <= win;
            last   <= win;
            hcnt   <= '0;
            sclk_q <= 1'b0;
          end
        end
        FRONT: if (tc) sclk_q <= 1'b1;
        SHIFT: begin
          // sample MISO in the first clk cycle of each SCLK-high half
          if (sclk_q && cnt == CNT_LOAD) rx <= {rx[14:0], MISO};
          if (tc) begin
            sclk_q <= ~sclk_q;
            hcnt   <= hcnt + 5'd1;
            if (sclk_q && hcnt != 5'd30) tx <= {tx[14:0], 1'b0};
          end
        end
        BACK: begin
          if (tc) begin
            done  <= onehot(owner);
            err   <= illegal;
            rdata <= illegal ? 16'h0000 : rx;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign SCLK      = sclk_q;
  assign MOSI      = active & tx[15];
  assign ch1_ss_n  = ~(active && sel_q == 3'd0);
  assign ch2_ss_n  = ~(active && sel_q == 3'd1);
  assign ch3_ss_n  = ~(active && sel_q == 3'd2);
  assign trig_ss_n = ~(active && sel_q == 3'd3);
  assign EEP_ss_n  = ~(active && sel_q == 3'd4);

endmodule

// File: tb/tb_spi_bus_arb.sv
// Directed bench for spi_bus_arb with SCLK_DIV = 4.
// A frame granted at cycle T selects T+1..T+132, pulses done at T+133 and
// allows the next grant at T+137.
`define CHK(tag, obs, exp) begin \
  n_cmp++; \
  assert ((obs) === (exp)) else begin \
    n_err++; \
    $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
  end \
end

module tb_spi_bus_arb;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [15:0] wdata_0 = '0, wdata_1 = '0, wdata_2 = '0;
  logic [2:0]  sel_0 = '0, sel_1 = '0, sel_2 = '0;
  logic [2:0]  gnt, done;
  logic        err, busy, SCLK, MOSI, MISO;
  logic [15:0] rdata;
  logic        ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n;

  int n_cmp = 0;
  int n_err = 0;

  spi_bus_arb #(.SCLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .req(req),
    .wdata_0(wdata_0), .wdata_1(wdata_1), .wdata_2(wdata_2),
    .sel_0(sel_0), .sel_1(sel_1), .sel_2(sel_2),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ch1_ss_n(ch1_ss_n), .ch2_ss_n(ch2_ss_n), .ch3_ss_n(ch3_ss_n),
    .trig_ss_n(trig_ss_n), .EEP_ss_n(EEP_ss_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and MISO slave model; per-frame statistics restart at each gnt.
  logic [4:0]  ssn;
  assign ssn = {EEP_ss_n, trig_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n};

  logic [15:0] miso_word = '0;
  int          miso_idx = 0;
  assign MISO = (miso_idx < 16) ? miso_word[15 - miso_idx] : 1'b0;

  int ss_first[5], ss_last[5], ss_cnt[5];
  int rises = 0, tot_rises = 0;
  logic [15:0] mosi_cap = '0;
  logic sclk_prev = 1'b0;
  int gnt_count = 0;
  int gnt_cyc[16], gnt_who[16];
  int done_count = 0, done_cyc = 0;
  logic [2:0]  done_val = '0;
  logic        done_err = 1'b0;
  logic [15:0] done_rdata = '0;
  int multi_low = 0, stray_err = 0, busy_last = 0;

  function automatic int decode(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 9;
    endcase
  endfunction

  always @(negedge clk) begin
    if (gnt != 3'b000) begin
      if (gnt_count < 16) begin
        gnt_cyc[gnt_count] <= cyc;
        gnt_who[gnt_count] <= decode(gnt);
      end
      gnt_count <= gnt_count + 1;
      for (int i = 0; i < 5; i++) begin
        ss_first[i] <= -1;
        ss_last[i]  <= -1;
        ss_cnt[i]   <= 0;
      end
      rises    <= 0;
      mosi_cap <= '0;
      miso_idx <= 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!ssn[i]) begin
          if (ss_first[i] < 0) ss_first[i] <= cyc;
          ss_last[i] <= cyc;
          ss_cnt[i]  <= ss_cnt[i] + 1;
        end
      end
      if (SCLK && !sclk_prev) begin
        rises    <= rises + 1;
        mosi_cap <= {mosi_cap[14:0], MOSI};
      end
      if (!SCLK && sclk_prev && miso_idx < 16) miso_idx <= miso_idx + 1;
    end
    if (SCLK && !sclk_prev) tot_rises <= tot_rises + 1;
    sclk_prev <= SCLK;
    if (done != 3'b000) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
      done_val   <= done;
      done_err   <= err;
      done_rdata <= rdata;
    end
    if (err && done == 3'b000) stray_err <= stray_err + 1;
    if ($countones(~ssn) > 1 || (ssn != 5'h1f && !busy)) multi_low <= multi_low + 1;
    if (busy) busy_last <= cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int n, input string tag);
    for (int k = 0; k < 300 && gnt_count < n; k++) step();
    `CHK(tag, gnt_count, n)
  endtask

  task automatic wait_done(input int n, input string tag);
    for (int k = 0; k < 300 && done_count < n; k++) step();
    `CHK(tag, done_count, n)
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 50 && busy; k++) step();
    `CHK(tag, busy, 1'b0)
  endtask

  int t0, rb, dc;

  initial begin
    // reset state
    #2 rst = 1'b1;
    #1;
    `CHK("rst_ss", ssn, 5'h1f)
    `CHK("rst_bus", {SCLK, MOSI, busy, err}, 4'b0000)
    `CHK("rst_pulses", {gnt, done}, 6'b000000)
    `CHK("rst_rdata", rdata, 16'h0000)
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();

    // single write to ch1
    miso_word = 16'h1234; wdata_0 = 16'hA5C3; sel_0 = 3'd0; req = 3'b001;
    wait_gnt(1, "w_gnt");
    req = 3'b000;
    t0 = gnt_cyc[0];
    `CHK("w_who", gnt_who[0], 0)
    wait_done(1, "w_done");
    wait_idle("w_idle");
    `CHK("w_ss_first", ss_first[0], t0 + 1)
    `CHK("w_ss_last", ss_last[0], t0 + 132)
    `CHK("w_other_ss", ss_cnt[1] + ss_cnt[2] + ss_cnt[3] + ss_cnt[4], 0)
    `CHK("w_rises", rises, 16)
    `CHK("w_mosi", mosi_cap, 16'hA5C3)
    `CHK("w_done_cyc", done_cyc, t0 + 133)
    `CHK("w_done_val", {done_val, done_err}, 4'b0010)
    `CHK("w_rdata", done_rdata, 16'h1234)
    `CHK("w_busy_last", busy_last, t0 + 136)

    // EEPROM read; payload and select changed after gnt must not matter
    miso_word = 16'h3C5A; wdata_2 = 16'h0F0F; sel_2 = 3'd4; req = 3'b100;
    wait_gnt(2, "e_gnt");
    req = 3'b000; wdata_2 = 16'hFFFF; sel_2 = 3'd0;
    `CHK("e_who", gnt_who[1], 2)
    wait_done(2, "e_done");
    wait_idle("e_idle");
    `CHK("e_eep_cnt", ss_cnt[4], 132)
    `CHK("e_other_ss", ss_cnt[0] + ss_cnt[1] + ss_cnt[2] + ss_cnt[3], 0)
    `CHK("e_mosi", mosi_cap, 16'h0F0F)
    `CHK("e_done_val", {done_val, done_err}, 4'b1000)
    `CHK("e_rdata", done_rdata, 16'h3C5A)

    // contention: 3'b111 dropped per grant, then 3'b101 held
    sel_0 = 3'd1; sel_1 = 3'd2; sel_2 = 3'd3; miso_word = 16'h0001;
    req = 3'b111;
    for (int g = 3; g <= 5; g++) begin
      wait_gnt(g, "c_gnt");
      req[gnt_who[g-1]] = 1'b0;
    end
    req = 3'b101;
    for (int g = 6; g <= 8; g++) wait_gnt(g, "c_gnt");
    req = 3'b000;
    `CHK("c_order", {gnt_who[2][1:0], gnt_who[3][1:0], gnt_who[4][1:0],
                     gnt_who[5][1:0], gnt_who[6][1:0], gnt_who[7][1:0]},
                    {2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0})
    for (int k = 2; k < 7; k++)
      `CHK("c_spacing", gnt_cyc[k+1] - gnt_cyc[k], 34 * D + 1)
    wait_done(8, "c_done");
    wait_idle("c_idle");

    // illegal select
    miso_word = 16'hFFFF; wdata_1 = 16'h5555; sel_1 = 3'd6; req = 3'b010;
    wait_gnt(9, "i_gnt");
    req = 3'b000;
    t0 = gnt_cyc[8];
    wait_done(9, "i_done");
    wait_idle("i_idle");
    `CHK("i_who", gnt_who[8], 1)
    `CHK("i_no_ss", ss_cnt[0] + ss_cnt[1] + ss_cnt[2] + ss_cnt[3] + ss_cnt[4], 0)
    `CHK("i_rises", rises, 16)
    `CHK("i_mosi", mosi_cap, 16'h5555)
    `CHK("i_done_err", {done_val, done_err}, 4'b0101)
    `CHK("i_rdata", done_rdata, 16'h0000)
    `CHK("i_done_cyc", done_cyc, t0 + 133)

    // request withdrawn while busy
    miso_word = 16'hBEEF; wdata_0 = 16'h1357; sel_0 = 3'd3; req = 3'b001;
    rb = tot_rises;
    wait_gnt(10, "r_gnt");
    req = 3'b000;
    repeat (20) step();
    req = 3'b010;
    step();
    req = 3'b000;
    wait_done(10, "r_done");
    repeat (250) step();
    `CHK("r_gnt_count", gnt_count, 10)
    `CHK("r_frames", tot_rises - rb, 16)
    `CHK("r_busy", busy, 1'b0)
    `CHK("r_trig_cnt", ss_cnt[3], 132)
    `CHK("r_rdata", done_rdata, 16'hBEEF)

    // reset mid-frame; the aborted frame belongs to requester 1
    wdata_1 = 16'hFACE; sel_1 = 3'd1; req = 3'b010;
    wait_gnt(11, "x_gnt");
    req = 3'b000;
    dc = done_count;
    for (int k = 0; k < 300 && rises < 8; k++) step();
    `CHK("x_rises", rises, 8)
    rst = 1'b1;
    #1;
    `CHK("x_ss", ssn, 5'h1f)
    `CHK("x_bus", {SCLK, MOSI, busy, err}, 4'b0000)
    `CHK("x_pulses", {gnt, done}, 6'b000000)
    `CHK("x_rdata", rdata, 16'h0000)
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    `CHK("x_no_done", done_count, dc)
    step();
    // pointer is back at requester 0, so 1 outranks 2
    req = 3'b110;
    wait_gnt(12, "x_gnt2");
    req = 3'b000;
    `CHK("x_winner", gnt_who[11], 1)
    wait_done(dc + 1, "x_done");
    wait_idle("x_idle");
    `CHK("x_done_val", {done_val, done_err}, 4'b0100)
    `CHK("x_ch2_cnt", ss_cnt[1], 132)

    `CHK("g_one_ss", multi_low, 0)
    `CHK("g_stray_err", stray_err, 0)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
